// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: I/O register map,
// status-word bit layout and the address-region decode.
package data_mem_pkg;

    localparam logic [31:0] ADDR_IO_DATA   = 32'h0000_0400;
    localparam logic [31:0] ADDR_IO_STATUS = 32'h0000_0404;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_MSB = 7;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_IO_DATA,
        REGION_IO_STATUS
    } region_e;

    // Decode on the word address; the byte offset never reaches this function.
    // I/O registers are tested first so they win if RAM were ever sized over them.
    function automatic region_e decode_region(input logic [29:0] word_addr,
                                              input int unsigned ram_words);
        if (word_addr == ADDR_IO_DATA[31:2])
            return REGION_IO_DATA;
        else if (word_addr == ADDR_IO_STATUS[31:2])
            return REGION_IO_STATUS;
        else if ({2'b00, word_addr} < ram_words)
            return REGION_RAM;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/data_mem_responder_io_post_fifo.sv
// Write-posting FIFO for the I/O data port: valid/ready drain side,
// pre-qualified push from the address decoder.
module io_post_fifo
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          io_ready,
    output logic          io_valid,
    output logic [W-1:0]  io_data,
    output logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [W-1:0]  entry_q [DEPTH];

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign io_valid = !empty;
    assign pop      = io_valid && io_ready;
    assign count    = count_reg;
    assign io_data  = entry_q[head_reg];

    // One storage register per slot; contents are don't-care after reset
    // because count gates visibility.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [W-1:0] data_reg;

        // Capture the pushed word when the tail points at this slot.
        always_ff @(posedge clk) begin
            if (push && (tail_reg == PW'(gi)))
                data_reg <= push_data;
        end

        assign entry_q[gi] = data_reg;
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push)
                tail_reg <= tail_reg + PW'(1);
            if (pop)
                head_reg <= head_reg + PW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for a pipelined CPU: zero-latency RAM reads,
// posted I/O writes through a small FIFO, and a status register.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [31:0] io_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              wr_io_data;
    logic              wr_io_status;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              ovf_reg;
    logic [31:0]       status_word;
    logic              unused_addr_lsbs;

    // RAM has an asynchronous read port: the CPU captures ReadData on the
    // same edge the address is presented, so no read register is possible.
    logic [31:0] ram [RAM_WORDS];

    // The byte offset within a word is deliberately ignored.
    assign unused_addr_lsbs = ^ALUOutM[1:0];

    assign region       = decode_region(ALUOutM[31:2], RAM_WORDS);
    assign ram_idx      = ALUOutM[RAM_AW+1:2];
    assign ram_we       = MemWriteM && (region == REGION_RAM);
    assign wr_io_data   = MemWriteM && (region == REGION_IO_DATA);
    assign wr_io_status = MemWriteM && (region == REGION_IO_STATUS);

    // A full FIFO still takes a push when the sink drains a word on the same edge.
    assign fifo_push = wr_io_data && (!fifo_full || fifo_pop);
    assign overflow  = wr_io_data && fifo_full && !fifo_pop;

    // RAM write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= WriteDataM;
    end

    // Sticky overflow flag; a new overflow beats a software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf_reg <= 1'b0;
        else if (overflow)
            ovf_reg <= 1'b1;
        else if (wr_io_status && WriteDataM[STAT_OVF_BIT])
            ovf_reg <= 1'b0;
    end

    // Assemble the status register image.
    always_comb begin
        status_word = '0;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = ovf_reg;
        status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = 4'(fifo_count);
    end

    // Load-data mux; IO_DATA is write-only and unmapped space reads zero.
    always_comb begin
        ReadData = '0;
        case (region)
            REGION_RAM:       ReadData = ram[ram_idx];
            REGION_IO_STATUS: ReadData = status_word;
            default:          ReadData = '0;
        endcase
    end

    io_post_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (WriteDataM),
        .io_ready  (io_ready),
        .io_valid  (io_valid),
        .io_data   (io_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue/array reference model of the memory map.
module tb_data_mem_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        io_valid;
    logic        io_ready;
    logic [31:0] io_data;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model state
    logic [31:0] m_ram   [256];
    bit          m_known [256];
    logic [31:0] m_q[$];
    bit          m_ovf;

    logic [31:0] rd;
    logic [31:0] iod;
    logic        vld;

    always #5 clk = ~clk;

    data_mem_responder #(
        .RAM_WORDS  (256),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadData   (ReadData),
        .io_valid   (io_valid),
        .io_ready   (io_ready),
        .io_data    (io_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0]   = (m_q.size() == 0);
        s[1]   = (m_q.size() == DEPTH);
        s[2]   = m_ovf;
        s[7:4] = 4'(m_q.size());
        return s;
    endfunction

    // One bus cycle: drive at the falling edge, check combinational outputs,
    // then advance the model to the state after the next rising edge.
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic rdy, output logic [31:0] rd_o, output logic vld_o,
                        output logic [31:0] iod_o);
        bit full_before;
        bit pop;
        bit ovf_set;
        bit clr;
        @(negedge clk);
        MemWriteM  = we;
        ALUOutM    = addr;
        WriteDataM = wd;
        io_ready   = rdy;
        #1;
        rd_o  = ReadData;
        vld_o = io_valid;
        iod_o = io_data;
        txn++;
        $display("txn %0d we=%0b addr=%08h wd=%08h rdy=%0b rd=%08h io_valid=%0b io_data=%08h",
                 txn, we, addr, wd, rdy, rd_o, vld_o, iod_o);

        if (addr < 32'd1024) begin
            if (m_known[addr[9:2]])
                check_eq("ram_read", rd_o, m_ram[addr[9:2]]);
        end else if (addr[31:2] == 30'h101) begin
            check_eq("status_read", rd_o, model_status());
        end else begin
            check_eq("zero_read", rd_o, 32'h0);
        end
        check_eq("io_valid", {31'b0, vld_o}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0)
            check_eq("io_data", iod_o, m_q[0]);

        full_before = (m_q.size() == DEPTH);
        pop         = (m_q.size() != 0) && rdy;
        ovf_set     = 1'b0;
        clr         = 1'b0;
        if (pop)
            void'(m_q.pop_front());
        if (we) begin
            if (addr < 32'd1024) begin
                m_ram[addr[9:2]]   = wd;
                m_known[addr[9:2]] = 1'b1;
            end else if (addr[31:2] == 30'h100) begin
                if (!full_before || pop)
                    m_q.push_back(wd);
                else
                    ovf_set = 1'b1;
            end else if (addr[31:2] == 30'h101) begin
                clr = wd[2];
            end
        end
        if (ovf_set)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        int          sel;

        foreach (m_known[i]) m_known[i] = 1'b0;
        m_ovf      = 1'b0;
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h404;
        WriteDataM = 32'h0;
        io_ready   = 1'b0;

        #12;
        check_eq("reset_io_valid", {31'b0, io_valid}, 32'h0);
        check_eq("reset_status", ReadData, 32'h1);
        @(negedge clk);
        reset = 1'b1;

        // RAM write then zero-latency read, and read-before-write on a collision
        step(1'b1, 32'h010, 32'hDEADBEEF, 1'b0, rd, vld, iod);
        step(1'b0, 32'h010, 32'h0, 1'b0, rd, vld, iod);
        check_eq("ram_wr_rd", rd, 32'hDEADBEEF);
        step(1'b1, 32'h012, 32'h12345678, 1'b0, rd, vld, iod);
        check_eq("ram_rbw_old", rd, 32'hDEADBEEF);
        step(1'b1, 32'h010, 32'hDEADBEEF, 1'b0, rd, vld, iod);
        check_eq("ram_rbw_new", rd, 32'h12345678);

        // Fill beyond capacity with the sink stalled, then drain
        for (int i = 1; i <= 5; i++)
            step(1'b1, 32'h400, 32'(i), 1'b0, rd, vld, iod);
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("overflow_status", rd, 32'h46);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 32'h800, 32'h0, 1'b1, rd, vld, iod);
            check_eq("drain_valid", {31'b0, vld}, 32'h1);
            check_eq("drain_data", iod, 32'(i));
        end
        step(1'b0, 32'h800, 32'h0, 1'b1, rd, vld, iod);
        check_eq("drained_valid", {31'b0, vld}, 32'h0);

        // Software clear of the overflow flag
        step(1'b1, 32'h404, 32'h4, 1'b0, rd, vld, iod);
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("ovf_clear_status", rd, 32'h1);

        // Push into a full FIFO while it drains on the same edge
        for (int i = 5; i <= 8; i++)
            step(1'b1, 32'h400, 32'(i), 1'b0, rd, vld, iod);
        step(1'b1, 32'h400, 32'h9, 1'b1, rd, vld, iod);
        check_eq("full_pushpop_head", iod, 32'h5);
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("full_pushpop_status", rd, 32'h42);
        for (int i = 6; i <= 9; i++) begin
            step(1'b0, 32'h800, 32'h0, 1'b1, rd, vld, iod);
            check_eq("pushpop_order", iod, 32'(i));
        end
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("pushpop_final_status", rd, 32'h1);

        // Unmapped reads return zero and unmapped writes change nothing
        step(1'b1, 32'h000, 32'h11111111, 1'b0, rd, vld, iod);
        step(1'b1, 32'h400, 32'h0000000A, 1'b0, rd, vld, iod);
        step(1'b0, 32'h800, 32'h0, 1'b0, rd, vld, iod);
        check_eq("unmapped_read", rd, 32'h0);
        step(1'b1, 32'h800, 32'h55, 1'b0, rd, vld, iod);
        step(1'b0, 32'h000, 32'h0, 1'b0, rd, vld, iod);
        check_eq("unmapped_no_alias", rd, 32'h11111111);
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("unmapped_fifo_status", rd, 32'h10);
        step(1'b0, 32'h800, 32'h0, 1'b1, rd, vld, iod);
        check_eq("unmapped_fifo_head", iod, 32'h0000000A);

        // Reset in the middle of traffic with three words queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h400, 32'h21 + 32'(i), 1'b0, rd, vld, iod);
        step(1'b0, 32'h800, 32'h0, 1'b0, rd, vld, iod);
        check_eq("pre_reset_valid", {31'b0, vld}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_valid", {31'b0, io_valid}, 32'h0);
        m_q.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);
        check_eq("post_reset_status", rd, 32'h1);
        step(1'b0, 32'h010, 32'h0, 1'b0, rd, vld, iod);
        check_eq("ram_kept_over_reset", rd, 32'hDEADBEEF);

        // Randomized traffic against the model
        repeat (400) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)
                a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            else if (sel <= 5)
                a = 32'h400 | 32'($urandom_range(0, 3));
            else if (sel == 6)
                a = 32'h404 | 32'($urandom_range(0, 3));
            else if (sel == 7)
                a = 32'h408 + (32'($urandom_range(0, 100)) << 2);
            else
                a = 32'h1000 | $urandom();
            w = $urandom();
            step(1'($urandom_range(0, 1)), a, w, 1'($urandom_range(0, 2) == 0), rd, vld, iod);
        end
        step(1'b0, 32'h404, 32'h0, 1'b0, rd, vld, iod);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256: number of 32-bit words in data RAM.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries in the I/O write-posting FIFO, a power of two of at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MemWriteM  input  1  memory-stage write strobe from the CPU.
REQ-006 SHALL have port ALUOutM  input  32  memory-stage byte address from the CPU.
REQ-007 SHALL have port WriteDataM  input  32  memory-stage store data from the CPU.
REQ-008 SHALL have port ReadData  output  32  load data returned to the CPU in the same cycle.
REQ-009 SHALL have port io_valid  output  1  posted I/O word available to the sink.
REQ-010 SHALL have port io_ready  input  1  sink accepts the word this cycle.
REQ-011 SHALL have port io_data  output  32  posted I/O word at the FIFO head.

Function
REQ-012 SHALL decode addresses with ALUOutM[1:0] ignored: RAM at 0x000 to 4*RAM_WORDS-1, IO_DATA at 0x400, IO_STATUS at 0x404; every other address is unmapped.
REQ-013 SHALL return ReadData combinationally from RAM[ALUOutM[9:2]] for RAM addresses, with zero added latency, because the CPU samples ReadData into its MEM/WB register on the same edge.
REQ-014 SHALL write WriteDataM into the addressed RAM word on the rising edge when MemWriteM=1 and the address is in RAM.
REQ-015 SHALL return the RAM value stored before the edge when a read and a write hit the same RAM word in the same cycle.
REQ-016 SHALL, for a write to IO_DATA, push WriteDataM into the FIFO tail on the edge if the FIFO is not full.
REQ-017 SHALL drop the write and set the sticky flag ovf when a write to IO_DATA finds the FIFO full, unless a pop occurs in the same cycle.
REQ-018 SHALL accept a push into a full FIFO when a pop occurs on the same edge; the count then stays at FIFO_DEPTH.
REQ-019 SHALL drive io_valid=1 exactly when count>0, and io_data SHALL equal the head entry.
REQ-020 SHALL pop on an edge where io_valid=1 and io_ready=1; io_ready while empty has no effect.
REQ-021 SHALL keep count unchanged on a simultaneous push and pop in a non-empty FIFO.
REQ-022 SHALL keep head, tail and count stable while io_valid=1 and io_ready=0.
REQ-023 SHALL wrap head and tail pointers modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-024 SHALL read IO_STATUS as: bit0=empty, bit1=full, bit2=ovf, bits[7:4]=count zero-extended, all other bits 0.
REQ-025 SHALL clear ovf when IO_STATUS is written with WriteDataM[2]=1; if an overflow occurs on the same edge, ovf SHALL stay set.
REQ-026 SHALL read 0 from IO_DATA and from unmapped addresses, and SHALL ignore writes to unmapped addresses.

Reset
REQ-027 SHALL, while reset=0, clear head, tail, count and ovf asynchronously, and SHALL hold io_valid=0.
REQ-028 SHALL NOT initialise RAM contents on reset; the RAM keeps its contents across reset.
REQ-029 SHALL discard the FIFO contents on a reset asserted mid-operation, and SHALL accept no push or pop until the first edge after reset returns to 1.

Structure
REQ-030 SHALL take ADDR_IO_DATA, ADDR_IO_STATUS, the status bit indices and the region-decode enum from the shared package data_mem_pkg.
REQ-031 SHALL place the FIFO, with its pointers, count, full and empty logic, in the sub-module io_post_fifo; address decode, RAM and ovf stay in the top module.

Verification
REQ-032 SHALL check: write 0xDEADBEEF to 0x010, then read 0x010 on the next cycle -> ReadData=0xDEADBEEF in the same cycle as the address.
REQ-033 SHALL check: with io_ready=0, write 1,2,3,4,5 to 0x400 -> status reads full=1, ovf=1, count=4; then with io_ready=1 -> io_data yields 1,2,3,4 and io_valid=0 afterwards.
REQ-034 SHALL check: with the FIFO full and io_ready=1, write 9 to 0x400 in that cycle -> ovf stays 0, count stays 4, and 9 exits last.
REQ-035 SHALL check: set ovf, then write 0x4 to 0x404 -> the status read returns bit2=0.
REQ-036 SHALL check: read 0x800 -> ReadData=0; write 0x55 to 0x800 -> no RAM word and no FIFO state changes.
REQ-037 SHALL check: assert reset with 3 entries queued -> io_valid=0 immediately, status=0x1 after release, and RAM word 0x010 still holds 0xDEADBEEF.
